ps2_multi_line_conditioner: RTL and testbench
=============================================

Name: ps2_multi_line_conditioner

Overview:
Parametrised, multi-line successor to the PS/2 two-wire conditioner. It conditions N open-drain input lines (PS/2 CLK/DATA of one or more ports) into the clk domain. Each line passes through an optional N-stage CDC synchroniser, then a programmable debouncer with a registered output. The block also provides per-line edge strobes and saturating glitch counters. It sits between the pads and the PS/2 receive/transmit FSMs.

Parameters:
N_LINES, 2, number of independent lines conditioned
SYNC_STAGES, 2, flip-flops in each synchroniser chain (legal 2..4)
DEB_MAX, 15, largest debounce exponent; debounce counter width is DEB_MAX+1
GLITCH_W, 8, width of each per-line glitch counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
lines_in  in  N_LINES  raw pad lines, idle high
sync_en  in  1  1 = use synchronised lines; 0 = feed raw lines straight to debouncers
deb_time  in  5  debounce exponent; reload = 2^min(deb_time, DEB_MAX)
glitch_clr  in  1  synchronous clear of all glitch counters
lines_out  out  N_LINES  conditioned, registered lines
rise  out  N_LINES  1-cycle strobe when lines_out[i] goes 0->1
fall  out  N_LINES  1-cycle strobe when lines_out[i] goes 1->0
glitch_cnt  out  N_LINES*GLITCH_W  packed counters; line i at [i*GLITCH_W +: GLITCH_W]

Behaviour:
- Reset (async, active-high): synchroniser flops = 1; lines_out = all 1; rise = fall = 0; glitch_cnt = 0; every debounce counter = 1 (reload for exponent 0); the deb_time shadow register = 0.
- Synchroniser: with sync_en=1, raw[i] = lines_in[i] delayed by SYNC_STAGES cycles. With sync_en=0, raw[i] = lines_in[i] directly. The chains keep running while bypassed.
- Reload value: R = 1 << min(deb_time, DEB_MAX).
  - deb_time is registered into a shadow register each cycle.
  - When the shadow register differs from deb_time, every line's counter is loaded with the new R on that edge. No output change occurs on that edge.
- Debounce, per line, each clk edge:
  - raw == out: cnt <= R. If cnt != R before this edge, a glitch has occurred (a partial excursion that did not reach expiry); glitch_cnt increments.
  - raw != out and cnt == 1: out <= raw, cnt <= R.
  - raw != out and cnt > 1: cnt <= cnt - 1.
- Latency: lines_out changes on the edge after raw has differed for R consecutive cycles. deb_time = 0 gives R = 1, i.e. a single registered stage. The total from pad to lines_out is SYNC_STAGES + R cycles.
- Edge strobes: rise/fall are registered together with out and are high for exactly the one cycle after out toggles. rise and fall are never both high on the same line.
- Glitch counter: saturates at 2^GLITCH_W-1. If glitch_clr and an increment occur in the same cycle, clear wins and the counter becomes 0.
- Lines are fully independent: a simultaneous toggle on all lines gives simultaneous strobes.
- Reset asserted mid-debounce: the in-progress count is discarded and all state returns to reset values.
- A deb_time change mid-count restarts the count with the new R and does not record a glitch.

Decomposition:
- Package ps2_cond_pkg holds:
  - PS2_IDLE_LEVEL = 1'b1
  - DEB_EXP_W = 5
  - a function deb_reload(exp, max) that returns the clamped 1 << exp.
- Sub-module ps2_line_debounce, one instance per line via generate, contains:
  - the synchroniser chain
  - the bypass mux
  - the counter
  - the out register
  - the edge strobes
  - the glitch counter
- The top level contains the deb_time shadow compare, the generate loop and the output packing.

Test Plan:
- Reset release, lines_in = 2'b11, sync_en=1, deb_time=0: lines_out = 11, glitch_cnt = 0. Drop line0 to 0 → lines_out[0] = 0 exactly 3 cycles later (SYNC_STAGES 2 + R 1), with fall[0] high for 1 cycle.
- deb_time = 4 (R = 16), line1 low for 10 cycles then high: lines_out[1] stays 1 and glitch_cnt[1] = 1. Hold low for 16+ cycles → lines_out[1] falls at cycle 2+16.
- deb_time = 20 with DEB_MAX = 15: the reload is clamped to 32768; verify the transition occurs at cycle 2+32768.
- sync_en = 0, deb_time = 0: pad toggle reaches lines_out in 1 cycle. Toggle both lines on the same cycle → rise = 11 on the same cycle.
- Force 300 glitches with GLITCH_W = 8: counter saturates at 255. Pulse glitch_clr together with a new glitch → counter = 0.
- Assert rst mid-count (cnt = 5 of 16): lines_out returns to 11 immediately (asynchronously), and the counter restarts at R on release.

Source files
------------

// File: rtl/ps2_cond_pkg.sv
// Shared constants and helpers for the PS/2 multi-line conditioner.
// The reload helper clamps the debounce exponent before forming the power of two.
package ps2_cond_pkg;

  localparam logic PS2_IDLE_LEVEL = 1'b1;
  localparam int   DEB_EXP_W      = 5;

  function automatic logic [31:0] deb_reload(input logic [DEB_EXP_W-1:0] exp_val,
                                             input int                   max_exp);
    logic [DEB_EXP_W-1:0] e;
    e = (int'(exp_val) > max_exp) ? DEB_EXP_W'(max_exp) : exp_val;
    return 32'd1 << e;
  endfunction

endpackage

// File: rtl/ps2_multi_line_conditioner_line.sv
// One conditioned line: synchroniser, bypass mux, debounce counter, registered
// output with edge strobes and a saturating glitch counter.
module ps2_line_debounce
  import ps2_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int GLITCH_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                line_i,
  input  logic                sync_en_i,
  input  logic [CNT_W-1:0]    reload_i,
  input  logic                reload_now_i,
  input  logic                glitch_clr_i,
  output logic                line_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   raw;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [GLITCH_W-1:0]    glitch_q, glitch_d;

  assign raw = sync_en_i ? sync_q[SYNC_STAGES-1] : line_i;

  // A return to the settled level before expiry counts as a glitch; a reload
  // caused by a debounce-time change does not.
  always_comb begin
    cnt_d    = cnt_q;
    out_d    = out_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    if (reload_now_i) begin
      cnt_d = reload_i;
    end else if (raw == out_q) begin
      cnt_d = reload_i;
      if (cnt_q != reload_i && glitch_q != '1) glitch_d = glitch_q + 1'b1;
    end else if (cnt_q == CNT_ONE) begin
      out_d  = raw;
      cnt_d  = reload_i;
      rise_d = raw;
      fall_d = ~raw;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    if (glitch_clr_i) glitch_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      cnt_q    <= CNT_ONE;
      out_q    <= PS2_IDLE_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], line_i};
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign line_o       = out_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign glitch_cnt_o = glitch_q;

endmodule

// File: rtl/ps2_multi_line_conditioner.sv
// Conditions N open-drain PS/2 lines into the clk domain; shares one debounce
// reload value and debounce-time change detection across all lines.
module ps2_multi_line_conditioner
  import ps2_cond_pkg::*;
#(
  parameter int N_LINES     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_MAX     = 15,
  parameter int GLITCH_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_LINES-1:0]          lines_in,
  input  logic                        sync_en,
  input  logic [DEB_EXP_W-1:0]        deb_time,
  input  logic                        glitch_clr,
  output logic [N_LINES-1:0]          lines_out,
  output logic [N_LINES-1:0]          rise,
  output logic [N_LINES-1:0]          fall,
  output logic [N_LINES*GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = DEB_MAX + 1;

  logic [DEB_EXP_W-1:0] deb_time_q;
  logic [CNT_W-1:0]     reload;
  logic                 reload_now;

  assign reload     = CNT_W'(deb_reload(deb_time, DEB_MAX));
  assign reload_now = (deb_time_q != deb_time);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) deb_time_q <= '0;
    else     deb_time_q <= deb_time;
  end

  for (genvar i = 0; i < N_LINES; i++) begin : g_line
    ps2_line_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .GLITCH_W   (GLITCH_W)
    ) u_line (
      .clk         (clk),
      .rst         (rst),
      .line_i      (lines_in[i]),
      .sync_en_i   (sync_en),
      .reload_i    (reload),
      .reload_now_i(reload_now),
      .glitch_clr_i(glitch_clr),
      .line_o      (lines_out[i]),
      .rise_o      (rise[i]),
      .fall_o      (fall[i]),
      .glitch_cnt_o(glitch_cnt[i*GLITCH_W +: GLITCH_W])
    );
  end

endmodule

// File: tb/tb_ps2_multi_line_conditioner.sv
// Self-checking bench for ps2_multi_line_conditioner: directed latency, clamp,
// glitch and reset scenarios plus random traffic against a run-length model.
module tb_ps2_multi_line_conditioner;

  localparam int N       = 2;
  localparam int SYNC    = 2;
  localparam int DEB_MAX = 15;
  localparam int GW      = 8;
  localparam int GMAX    = (1 << GW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    lines_in;
  logic            sync_en;
  logic [4:0]      deb_time;
  logic            glitch_clr;
  logic [N-1:0]    lines_out, rise, fall;
  logic [N*GW-1:0] glitch_cnt;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  ps2_multi_line_conditioner #(
    .N_LINES(N), .SYNC_STAGES(SYNC), .DEB_MAX(DEB_MAX), .GLITCH_W(GW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lines_in  (lines_in),
    .sync_en   (sync_en),
    .deb_time  (deb_time),
    .glitch_clr(glitch_clr),
    .lines_out (lines_out),
    .rise      (rise),
    .fall      (fall),
    .glitch_cnt(glitch_cnt)
  );

  // Reference model: a line toggles once the raw level has disagreed for R
  // consecutive edges; an interrupted disagreement run is a glitch.
  typedef struct packed {
    logic out;
    logic rise;
    logic fall;
    int   run;
    int   gl;
  } lineState_t;

  lineState_t   mLine [N];
  logic [N-1:0] mHist [SYNC];
  logic [4:0]   mShadow;
  logic [N-1:0] expOut, expRise, expFall;
  logic [N*GW-1:0] expGl;

  function automatic int reloadVal(input logic [4:0] d);
    int e;
    e = (int'(d) > DEB_MAX) ? DEB_MAX : int'(d);
    return 1 << e;
  endfunction

  function automatic lineState_t modelLine(input lineState_t s, input logic raw,
                                           input int r, input logic reload, input logic clr);
    lineState_t n;
    n = s;
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (reload) begin
      n.run = 0;
    end else if (raw != s.out) begin
      n.run = s.run + 1;
      if (n.run >= r) begin
        n.out  = raw;
        n.rise = raw;
        n.fall = ~raw;
        n.run  = 0;
      end
    end else begin
      if (s.run > 0 && s.gl < GMAX) n.gl = s.gl + 1;
      n.run = 0;
    end
    if (clr) n.gl = 0;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC; k++) mHist[k] <= '1;
      for (int i = 0; i < N; i++) mLine[i] <= '{1'b1, 1'b0, 1'b0, 0, 0};
      mShadow <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        mLine[i] <= modelLine(mLine[i], sync_en ? mHist[SYNC-1][i] : lines_in[i],
                              reloadVal(deb_time), mShadow != deb_time, glitch_clr);
      mHist[0] <= lines_in;
      for (int k = 1; k < SYNC; k++) mHist[k] <= mHist[k-1];
      mShadow <= deb_time;
    end
  end

  always_comb begin
    expOut  = '0;
    expRise = '0;
    expFall = '0;
    expGl   = '0;
    for (int i = 0; i < N; i++) begin
      expOut[i]            = mLine[i].out;
      expRise[i]           = mLine[i].rise;
      expFall[i]           = mLine[i].fall;
      expGl[i*GW +: GW]    = GW'(mLine[i].gl);
    end
  end

  task automatic doReset();
    rst        = 1'b1;
    lines_in   = '1;
    sync_en    = 1'b1;
    deb_time   = '0;
    glitch_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    @(negedge clk);
    nChecks++;
    if (lines_out !== 2'b11 || rise !== 2'b00 || fall !== 2'b00 || glitch_cnt !== '0)
      $display("[TB] FAIL reset_state: out=%b rise=%b fall=%b gl=%h, want out=11 rise=00 fall=00 gl=0",
               lines_out, rise, fall, glitch_cnt);
    else nPass++;
  endtask

  task automatic test_sync_latency();
    logic eo, ef;
    doReset();
    lines_in = 2'b10;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      eo = (j < 3);
      ef = (j == 3);
      nChecks++;
      if (lines_out[0] !== eo || fall[0] !== ef || rise[0] !== 1'b0)
        $display("[TB] FAIL sync_latency_cyc%0d: out0=%b fall0=%b rise0=%b, want out0=%b fall0=%b rise0=0",
                 j, lines_out[0], fall[0], rise[0], eo, ef);
      else nPass++;
    end
  endtask

  task automatic test_glitch_and_debounce();
    doReset();
    deb_time = 5'd4;
    repeat (3) @(negedge clk);
    lines_in = 2'b01;
    repeat (10) @(negedge clk);
    lines_in = 2'b11;
    repeat (6) @(negedge clk);
    nChecks++;
    if (lines_out[1] !== 1'b1 || glitch_cnt[GW +: GW] !== 8'd1)
      $display("[TB] FAIL short_pulse_glitch: out1=%b gl1=%0d, want out1=1 gl1=1",
               lines_out[1], glitch_cnt[GW +: GW]);
    else nPass++;
    lines_in = 2'b01;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      if (j == 17) begin
        nChecks++;
        if (lines_out[1] !== 1'b1)
          $display("[TB] FAIL deb16_early: out1=%b at cycle 17, want 1", lines_out[1]);
        else nPass++;
      end
      if (j == 18) begin
        nChecks++;
        if (lines_out[1] !== 1'b0 || fall[1] !== 1'b1)
          $display("[TB] FAIL deb16_edge: out1=%b fall1=%b at cycle 18, want out1=0 fall1=1",
                   lines_out[1], fall[1]);
        else nPass++;
      end
    end
    nChecks++;
    if ({lines_out, rise, fall, glitch_cnt} !== {expOut, expRise, expFall, expGl})
      $display("[TB] FAIL model_debounce: got %b_%b_%b_%h want %b_%b_%b_%h",
               lines_out, rise, fall, glitch_cnt, expOut, expRise, expFall, expGl);
    else nPass++;
  endtask

  task automatic test_clamp();
    doReset();
    deb_time = 5'd20;
    repeat (3) @(negedge clk);
    lines_in = 2'b10;
    repeat (2 + 32767) @(negedge clk);
    nChecks++;
    if (lines_out[0] !== 1'b1)
      $display("[TB] FAIL clamp_early: out0=%b at cycle 32769, want 1", lines_out[0]);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if (lines_out[0] !== 1'b0 || fall[0] !== 1'b1)
      $display("[TB] FAIL clamp_edge: out0=%b fall0=%b at cycle 32770, want out0=0 fall0=1",
               lines_out[0], fall[0]);
    else nPass++;
  endtask

  task automatic test_bypass_simultaneous();
    doReset();
    sync_en  = 1'b0;
    lines_in = 2'b00;
    @(negedge clk);
    nChecks++;
    if (lines_out !== 2'b00 || fall !== 2'b11 || rise !== 2'b00)
      $display("[TB] FAIL bypass_fall: out=%b fall=%b rise=%b, want out=00 fall=11 rise=00",
               lines_out, fall, rise);
    else nPass++;
    lines_in = 2'b11;
    @(negedge clk);
    nChecks++;
    if (lines_out !== 2'b11 || rise !== 2'b11 || fall !== 2'b00)
      $display("[TB] FAIL bypass_rise: out=%b rise=%b fall=%b, want out=11 rise=11 fall=00",
               lines_out, rise, fall);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if (rise !== 2'b00 || fall !== 2'b00)
      $display("[TB] FAIL strobe_width: rise=%b fall=%b, want 00 00", rise, fall);
    else nPass++;
  endtask

  task automatic test_saturate_clear();
    doReset();
    sync_en  = 1'b0;
    deb_time = 5'd1;
    @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      lines_in = 2'b10;
      @(negedge clk);
      lines_in = 2'b11;
      @(negedge clk);
    end
    nChecks++;
    if (glitch_cnt[0 +: GW] !== 8'd255 || glitch_cnt[GW +: GW] !== 8'd0 || lines_out !== 2'b11)
      $display("[TB] FAIL glitch_saturate: gl0=%0d gl1=%0d out=%b, want gl0=255 gl1=0 out=11",
               glitch_cnt[0 +: GW], glitch_cnt[GW +: GW], lines_out);
    else nPass++;
    lines_in = 2'b10;
    @(negedge clk);
    lines_in   = 2'b11;
    glitch_clr = 1'b1;
    @(negedge clk);
    glitch_clr = 1'b0;
    nChecks++;
    if (glitch_cnt[0 +: GW] !== 8'd0)
      $display("[TB] FAIL clear_wins: gl0=%0d, want 0", glitch_cnt[0 +: GW]);
    else nPass++;
    lines_in = 2'b10;
    @(negedge clk);
    lines_in = 2'b11;
    @(negedge clk);
    nChecks++;
    if (glitch_cnt[0 +: GW] !== 8'd1)
      $display("[TB] FAIL count_after_clear: gl0=%0d, want 1", glitch_cnt[0 +: GW]);
    else nPass++;
  endtask

  task automatic test_reset_mid_count();
    doReset();
    deb_time = 5'd4;
    repeat (3) @(negedge clk);
    lines_in = 2'b10;
    repeat (18) @(negedge clk);
    nChecks++;
    if (lines_out !== 2'b10)
      $display("[TB] FAIL pre_reset_level: out=%b, want 10", lines_out);
    else nPass++;
    lines_in = 2'b00;
    repeat (13) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nChecks++;
    if (lines_out !== 2'b11 || rise !== 2'b00 || fall !== 2'b00)
      $display("[TB] FAIL async_reset: out=%b rise=%b fall=%b, want out=11 rise=00 fall=00",
               lines_out, rise, fall);
    else nPass++;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      if (j == 17) begin
        nChecks++;
        if (lines_out !== 2'b11)
          $display("[TB] FAIL restart_early: out=%b at cycle 17, want 11", lines_out);
        else nPass++;
      end
      if (j == 18) begin
        nChecks++;
        if (lines_out !== 2'b00 || fall !== 2'b11)
          $display("[TB] FAIL restart_edge: out=%b fall=%b at cycle 18, want out=00 fall=11",
                   lines_out, fall);
        else nPass++;
      end
    end
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(3) == 0)   lines_in = N'($urandom);
      if ($urandom_range(199) == 0) sync_en = ~sync_en;
      if ($urandom_range(149) == 0) deb_time = 5'($urandom_range(3));
      glitch_clr = ($urandom_range(63) == 0);
      @(negedge clk);
      nChecks++;
      if ({lines_out, rise, fall, glitch_cnt} !== {expOut, expRise, expFall, expGl})
        $display("[TB] FAIL random_cyc%0d: got out=%b rise=%b fall=%b gl=%h want out=%b rise=%b fall=%b gl=%h",
                 c, lines_out, rise, fall, glitch_cnt, expOut, expRise, expFall, expGl);
      else nPass++;
    end
    glitch_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_sync_latency();
    test_glitch_and_debounce();
    test_clamp();
    test_bypass_simultaneous();
    test_saturate_clear();
    test_reset_mid_count();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
